// File: rtl/vga_scan_compositor_if.sv
// Scan-side bundle: pixel coordinates out to overlay generators, colours back in,
// and the aligned pin outputs. The master drives timing and pins; the slave is the consumer side.
interface vga_scan_compositor_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic [5:0] overlay_rgb;
    logic [5:0] bg_rgb;
    logic       hsync_o;
    logic       vsync_o;
    logic [5:0] rgb_o;
    logic       frame_tick;
    logic [7:0] frame_count;

    modport master (
        output x, y, active, hsync_o, vsync_o, rgb_o, frame_tick, frame_count,
        input  overlay_rgb, bg_rgb
    );

    modport slave (
        input  x, y, active, hsync_o, vsync_o, rgb_o, frame_tick, frame_count,
        output overlay_rgb, bg_rgb
    );
endinterface

// File: rtl/vga_scan_compositor.sv
// Purpose: 640x480@60 scan timing plus colour-key compositing of overlay over background.
// Latency: pins (hsync_o/vsync_o/rgb_o) lag the presented x/y by one pix_en cycle.
// Backpressure: none; pix_en low freezes every register. SCAN_TESTBARS_EN swaps bg_rgb for colour bars.
module vga_scan_compositor #(
    parameter int         H_ACTIVE    = 640,
    parameter int         H_FP        = 16,
    parameter int         H_SYNC      = 96,
    parameter int         H_BP        = 48,
    parameter int         V_ACTIVE    = 480,
    parameter int         V_FP        = 10,
    parameter int         V_SYNC      = 2,
    parameter int         V_BP        = 33,
    parameter logic       SYNC_ACTIVE = 1'b0,
    parameter logic [5:0] KEY_COLOR   = 6'b100001
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_en,
    vga_scan_compositor_if.master  bus
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_q;
    logic [9:0] y_q;
    logic       hsync_q;
    logic       vsync_q;
    logic [5:0] rgb_q;
    logic       tick_q;
    logic [7:0] frame_cnt_q;

    logic       active_c;
    logic       hs_raw;
    logic       vs_raw;
    logic       line_end;
    logic       frame_end;
    logic [5:0] background;
    logic [5:0] composite;

    assign active_c  = (x_q < H_VIS) && (y_q < V_VIS);
    assign hs_raw    = (x_q >= HS_START) && (x_q < HS_END);
    assign vs_raw    = (y_q >= VS_START) && (y_q < VS_END);
    assign line_end  = (x_q == H_LAST);
    assign frame_end = line_end && (y_q == V_LAST);

`ifdef SCAN_TESTBARS_EN
    // Eight 80-pixel bars keyed purely on x; the external background is not consulted.
    always_comb begin
        background = 6'b000000;
        if      (x_q < 10'd80)  background = 6'b111111;
        else if (x_q < 10'd160) background = 6'b111100;
        else if (x_q < 10'd240) background = 6'b001111;
        else if (x_q < 10'd320) background = 6'b001100;
        else if (x_q < 10'd400) background = 6'b110011;
        else if (x_q < 10'd480) background = 6'b110000;
        else if (x_q < 10'd560) background = 6'b000011;
    end
`else
    assign background = bus.bg_rgb;
`endif

    // Transparent overlay pixels show the background; blanking forces black.
    assign composite = !active_c                     ? 6'b000000  :
                       (bus.overlay_rgb == KEY_COLOR) ? background :
                                                        bus.overlay_rgb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            hsync_q     <= ~SYNC_ACTIVE;
            vsync_q     <= ~SYNC_ACTIVE;
            rgb_q       <= '0;
            tick_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // The tick self-clears every clock so it never stretches across stalled cycles.
            tick_q <= 1'b0;
            if (pix_en) begin
                hsync_q <= hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vsync_q <= vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                rgb_q   <= composite;
                if (line_end) begin
                    x_q <= '0;
                    y_q <= frame_end ? 10'd0 : y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
                if (frame_end) begin
                    tick_q      <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.active      = active_c;
    assign bus.hsync_o     = hsync_q;
    assign bus.vsync_o     = vsync_q;
    assign bus.rgb_o       = rgb_q;
    assign bus.frame_tick  = tick_q;
    assign bus.frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Bench for vga_scan_compositor: cycle scoreboard from an independent timing model,
// a keying vector table, and hand-written sync/frame/pix_en/reset sequences.
module tb_vga_scan_compositor;

    // Vertical timing shrunk so a whole frame fits a short run; sync width kept at 2 lines.
    localparam int VA = 16, VF = 2, VS = 2, VB = 2;
    localparam int VT = VA + VF + VS + VB;
    localparam int HT = 800;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;

    vga_scan_compositor_if bus();

    vga_scan_compositor #(
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pix_en(pix_en),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef logic [37:0] obs_t;
    obs_t exp_q[$];

    int         mx, my, last_x;
    logic       mhs, mvs, mft;
    logic [5:0] mrgb;
    logic [7:0] mfc;

    typedef struct {
        logic [5:0] ovl;
        logic [5:0] bg;
        logic [5:0] exp_rgb;
    } key_vec_t;
    key_vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t observe();
        return {bus.x, bus.y, bus.active, bus.hsync_o, bus.vsync_o,
                bus.rgb_o, bus.frame_tick, bus.frame_count};
    endfunction

    // Predict the edge from the model, let it happen, then compare against the DUT.
    task automatic tick();
        logic act;
        logic wrap;
        obs_t e;
        last_x = mx;
        if (!rst_n) begin
            mx = 0; my = 0; mhs = 1'b1; mvs = 1'b1; mrgb = 6'd0; mft = 1'b0; mfc = 8'd0;
        end else begin
            mft = 1'b0;
            if (pix_en) begin
                act  = (mx < 640) && (my < VA);
                mhs  = !(mx >= 656 && mx < 752);
                mvs  = !(my >= VA + VF && my < VA + VF + VS);
                mrgb = !act ? 6'd0 : (bus.overlay_rgb == 6'b100001 ? bus.bg_rgb : bus.overlay_rgb);
                wrap = (mx == HT - 1) && (my == VT - 1);
                mft  = wrap;
                if (wrap) mfc = mfc + 8'd1;
                if (mx == HT - 1) begin
                    mx = 0;
                    my = (my == VT - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        end
        exp_q.push_back({10'(mx), 10'(my), (mx < 640) && (my < VA), mhs, mvs, mrgb, mft, mfc});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("scan", 64'(observe()), 64'(e));
    endtask

    task automatic drive_rand();
        if (mx >= 640) bus.overlay_rgb = 6'b111111;
        else if ($urandom_range(3) == 0) bus.overlay_rgb = 6'b100001;
        else bus.overlay_rgb = 6'($urandom);
        bus.bg_rgb = 6'($urandom);
    endtask

    initial begin
        int hs_low0, vs_low, ft_cnt, nfalls, first_fall, blank_bad, n, run, run_chk;
        logic prev_hs;

        vecs[0] = '{6'b100001, 6'b000011, 6'b000011};
        vecs[1] = '{6'b110110, 6'b000011, 6'b110110};
        vecs[2] = '{6'b100001, 6'b100001, 6'b100001};
        vecs[3] = '{6'b000000, 6'b111111, 6'b000000};
        vecs[4] = '{6'b111111, 6'b000000, 6'b111111};
        vecs[5] = '{6'b100001, 6'b110000, 6'b110000};
        vecs[6] = '{6'b100000, 6'b000001, 6'b100000};
        vecs[7] = '{6'b000001, 6'b100001, 6'b000001};

        mx = 0; my = 0; last_x = 0; mhs = 1; mvs = 1; mrgb = 0; mft = 0; mfc = 0;
        bus.overlay_rgb = 6'd0;
        bus.bg_rgb = 6'd0;

        // Reset held for three clocks with pix_en high.
        rst_n = 1'b0;
        pix_en = 1'b1;
        repeat (3) begin drive_rand(); tick(); end
        check("rst_x", 64'(bus.x), 0);
        check("rst_y", 64'(bus.y), 0);
        check("rst_active", 64'(bus.active), 1);
        check("rst_hsync", 64'(bus.hsync_o), 1);
        check("rst_vsync", 64'(bus.vsync_o), 1);
        check("rst_rgb", 64'(bus.rgb_o), 0);
        check("rst_frame_count", 64'(bus.frame_count), 0);
        check("rst_frame_tick", 64'(bus.frame_tick), 0);

        // One full frame plus a margin, measuring sync pulses and the frame tick.
        rst_n = 1'b1;
        hs_low0 = 0; vs_low = 0; ft_cnt = 0; nfalls = 0; first_fall = 0; blank_bad = 0;
        prev_hs = 1'b1;
        for (int i = 0; i < VT * HT + 20; i++) begin
            drive_rand();
            tick();
            if (i < HT && !bus.hsync_o) hs_low0++;
            if (!bus.vsync_o) vs_low++;
            if (bus.frame_tick) ft_cnt++;
            if (last_x >= 640 && bus.rgb_o != 6'd0) blank_bad++;
            if (prev_hs && !bus.hsync_o) begin
                if (nfalls == 0) begin
                    check("hs_first_low_x", 64'(last_x), 656);
                    first_fall = i;
                end else if (nfalls == 1) begin
                    check("line_period", 64'(i - first_fall), HT);
                end
                nfalls++;
            end
            prev_hs = bus.hsync_o;
        end
        check("hs_low_line0", 64'(hs_low0), 96);
        check("vs_low_frame", 64'(vs_low), 2 * HT);
        check("frame_tick_count", 64'(ft_cnt), 1);
        check("frame_count_1", 64'(bus.frame_count), 1);
        check("blank_black", 64'(blank_bad), 0);

        // Seek to (10,10) and apply the keying table one pixel at a time.
        n = 0;
        while (!(bus.x == 10'd10 && bus.y == 10'd10) && n < VT * HT) begin
            drive_rand();
            tick();
            n++;
        end
        check("seek_x", 64'(bus.x), 10);
        check("seek_y", 64'(bus.y), 10);
        for (int i = 0; i < 8; i++) begin
            bus.overlay_rgb = vecs[i].ovl;
            bus.bg_rgb = vecs[i].bg;
            tick();
            check("key_vec", 64'(bus.rgb_o), 64'(vecs[i].exp_rgb));
        end

        // pix_en alternating: hsync low should stretch to 192 clocks.
        run = 0; run_chk = 0; prev_hs = bus.hsync_o;
        for (int i = 0; i < 4 * HT; i++) begin
            pix_en = (i % 2) == 0;
            drive_rand();
            tick();
            if (!bus.hsync_o) run++;
            if (!prev_hs && bus.hsync_o && run_chk == 0 && run > 0 && nfalls > 0) begin
                check("hs_low_halfrate", 64'(run), 192);
                run_chk = 1;
            end
            if (prev_hs && !bus.hsync_o) run = 1;
            prev_hs = bus.hsync_o;
        end
        check("halfrate_pulse_seen", 64'(run_chk), 1);

        // Reset pulse at x=300 while alternating, landing on a pix_en=0 edge.
        n = 0;
        while (bus.x != 10'd300 && n < 4 * HT) begin
            pix_en = !pix_en;
            drive_rand();
            tick();
            n++;
        end
        check("reach_x300", 64'(bus.x), 300);
        rst_n = 1'b0;
        pix_en = 1'b0;
        tick();
        check("midrst_x", 64'(bus.x), 0);
        check("midrst_y", 64'(bus.y), 0);
        check("midrst_hsync", 64'(bus.hsync_o), 1);
        check("midrst_rgb", 64'(bus.rgb_o), 0);
        check("midrst_frame_count", 64'(bus.frame_count), 0);
        rst_n = 1'b1;
        pix_en = 1'b1;
        bus.overlay_rgb = 6'b101010;
        bus.bg_rgb = 6'b000111;
        tick();
        check("post_rst_pixel00", 64'(bus.rgb_o), 64'(6'b101010));
        check("post_rst_x", 64'(bus.x), 1);
        for (int i = 0; i < 40; i++) begin
            pix_en = $urandom_range(1);
            drive_rand();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
